d_e_reg: RTL

D→E pipeline register of the five-stage MIPS core. It captures the decoded instruction word, PC, register operands, extended immediate and destination register from the D stage on each rising clock edge and presents them to the E stage (E_Controller, ALU, forwarding muxes). It supports hold (stall) and bubble insertion (flush) driven by the hazard unit. An optional bubble counter is available for performance debugging.

---
 rtl/d_e_if.sv | 31 +++
 rtl/d_e_reg.sv | 88 ++++++++
 2 files changed

// File: rtl/d_e_if.sv
// D->E pipeline register bundle: D-stage inputs, hazard controls and E-stage outputs.
// slave  : the pipeline register itself (d_e_reg)
// master : the surrounding core (D stage and hazard unit drive, E stage reads)
interface d_e_if;
  logic        stall_E;
  logic        flush_E;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] RD1_D;
  logic [31:0] RD2_D;
  logic [31:0] EXT_D;
  logic [4:0]  A3_D;
  logic [31:0] Instr_E;
  logic [31:0] PC_E;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] EXT_E;
  logic [4:0]  A3_E;
  logic        valid_E;
  logic [31:0] bubble_cnt;

  modport slave (
    input  stall_E, flush_E, Instr_D, PC_D, RD1_D, RD2_D, EXT_D, A3_D,
    output Instr_E, PC_E, RD1_E, RD2_E, EXT_E, A3_E, valid_E, bubble_cnt
  );

  modport master (
    output stall_E, flush_E, Instr_D, PC_D, RD1_D, RD2_D, EXT_D, A3_D,
    input  Instr_E, PC_E, RD1_E, RD2_E, EXT_E, A3_E, valid_E, bubble_cnt
  );
endinterface

// File: rtl/d_e_reg.sv
// D->E pipeline register of the five-stage MIPS core.
// Captures instruction, PC, operands, immediate and destination from D every
// rising edge; supports hold (stall_E) and bubble insertion (flush_E).
// Edge priority: reset > flush_E > stall_E > load.
// Optional feature macro: BUBBLE_CNT_EN -- adds a 32-bit saturating counter of
// inserted bubbles on bubble_cnt; when undefined bubble_cnt is tied to zero.
module d_e_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic   clk,
  input logic   reset,
  d_e_if.slave  bus
);

  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] rd1_r;
  logic [31:0] rd2_r;
  logic [31:0] ext_r;
  logic [4:0]  a3_r;
  logic        valid_r;

  // Pipeline register: a bubble is an all-zero instruction with A3=0 so E never writes a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r <= 32'h0000_0000;
      pc_r    <= RESET_PC;
      rd1_r   <= 32'h0000_0000;
      rd2_r   <= 32'h0000_0000;
      ext_r   <= 32'h0000_0000;
      a3_r    <= 5'd0;
      valid_r <= 1'b0;
    end else if (bus.flush_E) begin
      instr_r <= 32'h0000_0000;
      pc_r    <= RESET_PC;
      rd1_r   <= 32'h0000_0000;
      rd2_r   <= 32'h0000_0000;
      ext_r   <= 32'h0000_0000;
      a3_r    <= 5'd0;
      valid_r <= 1'b0;
    end else if (bus.stall_E) begin
      instr_r <= instr_r;
      pc_r    <= pc_r;
      rd1_r   <= rd1_r;
      rd2_r   <= rd2_r;
      ext_r   <= ext_r;
      a3_r    <= a3_r;
      valid_r <= valid_r;
    end else begin
      instr_r <= bus.Instr_D;
      pc_r    <= bus.PC_D;
      rd1_r   <= bus.RD1_D;
      rd2_r   <= bus.RD2_D;
      ext_r   <= bus.EXT_D;
      a3_r    <= bus.A3_D;
      // An all-zero word is the nop used for bubbles, so it never counts as real work.
      valid_r <= (bus.Instr_D != 32'h0000_0000);
    end
  end

  assign bus.Instr_E = instr_r;
  assign bus.PC_E    = pc_r;
  assign bus.RD1_E   = rd1_r;
  assign bus.RD2_E   = rd2_r;
  assign bus.EXT_E   = ext_r;
  assign bus.A3_E    = a3_r;
  assign bus.valid_E = valid_r;

`ifdef BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_r;

  // Saturating bubble counter: counts every flush edge (flush beats stall) and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_r <= 32'h0000_0000;
    end else if (bus.flush_E && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
      bubble_cnt_r <= bubble_cnt_r + 32'h0000_0001;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_r;
`else
  assign bus.bubble_cnt = 32'h0000_0000;
`endif

endmodule
